// File: rtl/mem_access_queue.sv
// mem_access_queue: M-to-W memory stage with an in-order queue of outstanding bus requests.
// Define MEM_MISALIGN_EN to raise w_exc on misaligned accesses instead of issuing them.
module mem_access_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m_valid,
    output logic                    m_ready,
    input  logic                    m_rm,
    input  logic                    m_wm,
    input  logic [1:0]              m_size,
    input  logic                    m_sext,
    input  logic [DATA_WIDTH-1:0]   m_addr,
    input  logic [DATA_WIDTH-1:0]   m_wdata,
    input  logic [4:0]              m_regw,
    input  logic [DATA_WIDTH-1:0]   m_pc,
    output logic                    dreq_valid,
    output logic [DATA_WIDTH-1:0]   dreq_addr,
    output logic [2:0]              dreq_size,
    output logic [DATA_WIDTH/8-1:0] dreq_strobe,
    output logic [DATA_WIDTH-1:0]   dreq_data,
    input  logic                    dresp_addr_ok,
    input  logic                    dresp_data_ok,
    input  logic [DATA_WIDTH-1:0]   dresp_data,
    output logic                    w_valid,
    output logic                    w_wen,
    output logic [4:0]              w_regw,
    output logic [DATA_WIDTH-1:0]   w_data,
    output logic [DATA_WIDTH-1:0]   w_pc,
    output logic                    w_exc
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int IDXW = $clog2(DATA_WIDTH);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic                  ent_load_q [DEPTH];
    logic [1:0]            ent_size_q [DEPTH];
    logic                  ent_sext_q [DEPTH];
    logic [OFFW-1:0]       ent_off_q  [DEPTH];
    logic [4:0]            ent_regw_q [DEPTH];
    logic [DATA_WIDTH-1:0] ent_pc_q   [DEPTH];

    logic [PTRW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]       count_q, count_d;

    logic                  w_valid_q, w_valid_d;
    logic                  w_wen_q, w_wen_d;
    logic [4:0]            w_regw_q, w_regw_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [DATA_WIDTH-1:0] w_pc_q, w_pc_d;
    logic                  w_exc_q, w_exc_d;

    logic                  is_mem, misalign, exc_cond;
    logic                  full, empty;
    logic                  issue, push, pop, direct_acc;
    logic [OFFW-1:0]       m_off;
    logic [DATA_WIDTH-1:0] resp_shift, load_data;
    logic [IDXW-1:0]       sign_idx;
    logic                  sign_bit;

    assign is_mem = m_rm | m_wm;
    assign full   = (count_q == CNTW'(DEPTH));
    assign empty  = (count_q == '0);
    assign m_off  = m_addr[OFFW-1:0];

`ifdef MEM_MISALIGN_EN
    always_comb begin
        case (m_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = m_addr[0];
            2'd2:    misalign = |m_addr[1:0];
            default: misalign = |m_addr[2:0];
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign exc_cond = is_mem & misalign;

    // Full blocks issue regardless of data_ok so dreq never depends combinationally on the response.
    assign issue      = ~reset & m_valid & is_mem & ~full & ~exc_cond;
    assign push       = issue & dresp_addr_ok;
    assign pop        = dresp_data_ok & ~empty;
    assign direct_acc = ~reset & m_valid & (~is_mem | exc_cond) & empty & ~dresp_data_ok;
    assign m_ready    = push | direct_acc;

    assign dreq_valid = issue;
    assign dreq_addr  = m_addr;
    assign dreq_size  = {1'b0, m_size};
    assign dreq_data  = m_wdata << {m_off, 3'b000};

    always_comb begin
        dreq_strobe = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            dreq_strobe[i] = (i >= 32'(m_off)) && ((i - 32'(m_off)) < (32'd1 << m_size));
        end
    end

    assign resp_shift = dresp_data >> {ent_off_q[rd_ptr_q], 3'b000};

    always_comb begin
        case (ent_size_q[rd_ptr_q])
            2'd0:    sign_idx = IDXW'(7);
            2'd1:    sign_idx = IDXW'(15);
            2'd2:    sign_idx = IDXW'(31);
            default: sign_idx = IDXW'(DATA_WIDTH - 1);
        endcase
    end

    assign sign_bit = ent_sext_q[rd_ptr_q] & resp_shift[sign_idx];

    always_comb begin
        load_data = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            load_data[i] = (i <= 32'(sign_idx)) ? resp_shift[i] : sign_bit;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        w_valid_d = pop | direct_acc;
        w_wen_d   = w_wen_q;
        w_regw_d  = w_regw_q;
        w_data_d  = w_data_q;
        w_pc_d    = w_pc_q;
        w_exc_d   = w_exc_q;

        if (push) wr_ptr_d = (wr_ptr_q == PTRW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PTRW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop) begin
            w_wen_d  = ent_load_q[rd_ptr_q] & (ent_regw_q[rd_ptr_q] != 5'd0);
            w_regw_d = ent_regw_q[rd_ptr_q];
            w_data_d = load_data;
            w_pc_d   = ent_pc_q[rd_ptr_q];
            w_exc_d  = 1'b0;
        end else if (direct_acc) begin
            w_wen_d  = ~exc_cond & (m_regw != 5'd0);
            w_regw_d = m_regw;
            w_data_d = m_addr;
            w_pc_d   = m_pc;
            w_exc_d  = exc_cond;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            w_valid_q <= '0;
            w_wen_q   <= '0;
            w_regw_q  <= '0;
            w_data_q  <= '0;
            w_pc_q    <= '0;
            w_exc_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            w_valid_q <= w_valid_d;
            w_wen_q   <= w_wen_d;
            w_regw_q  <= w_regw_d;
            w_data_q  <= w_data_d;
            w_pc_q    <= w_pc_d;
            w_exc_q   <= w_exc_d;
        end
    end

    // Entry payload needs no reset: validity is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_load_q[wr_ptr_q] <= m_rm;
            ent_size_q[wr_ptr_q] <= m_size;
            ent_sext_q[wr_ptr_q] <= m_sext;
            ent_off_q[wr_ptr_q]  <= m_off;
            ent_regw_q[wr_ptr_q] <= m_regw;
            ent_pc_q[wr_ptr_q]   <= m_pc;
        end
    end

    assign w_valid = w_valid_q;
    assign w_wen   = w_wen_q;
    assign w_regw  = w_regw_q;
    assign w_data  = w_data_q;
    assign w_pc    = w_pc_q;
    assign w_exc   = w_exc_q;

endmodule
